// File: rtl/case_6_sdiv_15s_7s_15_seq.sv
// Sequential signed divider, 15-bit dividend by 7-bit divisor.
// Restoring, one quotient bit per cycle, ap_start/ap_done handshake.
module case_6_sdiv_15s_7s_15_seq #(
   parameter int din0_WIDTH = 15,
   parameter int din1_WIDTH = 7
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   output logic                  ap_idle,
   output logic                  ap_ready,
   output logic                  ap_done,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [din0_WIDTH-1:0] quot,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  div_by_zero
);

   localparam int W0 = din0_WIDTH;
   localparam int W1 = din1_WIDTH;
   localparam int CW = $clog2(W0);
   localparam logic [CW-1:0] LAST = CW'(W0 - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t state_q;
   state_t state_d;

   // dvd shifts dividend bits out of the top and quotient bits in at the bottom
   logic [W0-1:0] dvd;
   logic [W1-1:0] dsr;
   logic [W1:0]   prem;
   logic [CW-1:0] cnt;
   logic          sign0;
   logic          sign1;
   logic          dz;

   logic [W0-1:0] a_abs;
   logic [W1-1:0] b_abs;
   logic [W1:0]   trial;
   logic [W1:0]   diff;
   logic          ge;

   assign a_abs = din0[W0-1] ? -din0 : din0;
   assign b_abs = din1[W1-1] ? -din1 : din1;

   // prem is always below |divisor| (<= 64), so its top bit is never lost
   assign trial = {prem[W1-1:0], dvd[W0-1]};
   assign diff  = trial - {1'b0, dsr};
   assign ge    = trial >= {1'b0, dsr};

   assign ap_idle  = (state_q == IDLE);
   assign ap_ready = ap_start & ap_idle;
   assign ap_done  = (state_q == DONE);

   // state register
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: fixed latency regardless of operands
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (ap_start) state_d = CALC;
         CALC: if (cnt == LAST) state_d = FIX;
         FIX:  state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // operand capture, restoring iterations and sign fix-up
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         dvd         <= '0;
         dsr         <= '0;
         prem        <= '0;
         cnt         <= '0;
         sign0       <= 1'b0;
         sign1       <= 1'b0;
         dz          <= 1'b0;
         quot        <= '0;
         rem         <= '0;
         div_by_zero <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ap_start) begin
                  dvd   <= a_abs;
                  dsr   <= b_abs;
                  sign0 <= din0[W0-1];
                  sign1 <= din1[W1-1];
                  dz    <= (din1 == '0);
                  prem  <= '0;
                  cnt   <= '0;
               end
            end
            CALC: begin
               prem <= ge ? diff : trial;
               dvd  <= {dvd[W0-2:0], ge};
               cnt  <= cnt + CW'(1);
            end
            FIX: begin
               if (dz) begin
                  quot        <= '0;
                  rem         <= '0;
                  div_by_zero <= 1'b1;
               end else begin
                  quot        <= (sign0 ^ sign1) ? -dvd : dvd;
                  rem         <= sign0 ? -prem[W1-1:0] : prem[W1-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
